// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : 1440x900 display timing generator. Owns the pixel counters, drives
//            draw_x/draw_y, and registers colour and sync for the VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 1440,
    parameter int H_FP     = 80,
    parameter int H_SYNC   = 152,
    parameter int H_BP     = 232,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 25,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  pix_r,
    input  logic [3:0]  pix_g,
    input  logic [3:0]  pix_b,
    output logic [10:0] draw_x,
    output logic [9:0]  draw_y,
    output logic        active,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int H_TOTAL_INT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_INT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11/10 bits wide; larger totals cannot be represented.
    generate
        if (H_TOTAL_INT > 2048) begin : g_h_total_chk
            $error("vga_timing: H_TOTAL exceeds 2048");
        end
        if (V_TOTAL_INT > 1024) begin : g_v_total_chk
            $error("vga_timing: V_TOTAL exceeds 1024");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL_INT - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL_INT - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [3:0]  vga_r_q, vga_r_d;
    logic [3:0]  vga_g_q, vga_g_d;
    logic [3:0]  vga_b_q, vga_b_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_tick_q, frame_tick_d;
    logic        in_active;
    logic        in_hs_win;
    logic        in_vs_win;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
    end

    assign in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign in_hs_win = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign in_vs_win = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    // Everything below is evaluated on the current count and lands on the pins
    // one edge later, keeping colour and sync mutually aligned.
    always_comb begin
        vga_r_d      = in_active ? pix_r : 4'd0;
        vga_g_d      = in_active ? pix_g : 4'd0;
        vga_b_d      = in_active ? pix_b : 4'd0;
        hsync_d      = in_hs_win ? HS_POL : ~HS_POL;
        vsync_d      = in_vs_win ? VS_POL : ~VS_POL;
        frame_tick_d = (h_cnt_q == 11'd0) && (v_cnt_q == V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q      <= 11'd0;
            v_cnt_q      <= 10'd0;
            vga_r_q      <= 4'd0;
            vga_g_q      <= 4'd0;
            vga_b_q      <= 4'd0;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vga_r_q      <= vga_r_d;
            vga_g_q      <= vga_g_d;
            vga_b_q      <= vga_b_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign draw_x     = h_cnt_q;
    assign draw_y     = v_cnt_q;
    assign active     = in_active;
    assign vga_r      = vga_r_q;
    assign vga_g      = vga_g_q;
    assign vga_b      = vga_b_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Directed self-checking bench: full-size instance for line timing,
//            reduced-size instances (both sync polarities) for frame timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pix_r, pix_g, pix_b;

    always #5 clk = ~clk;

    // Full-size instance
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        d_act, d_hs, d_vs, d_ft;
    logic [3:0]  d_r, d_g, d_b;

    // Reduced instance: H 8/2/3/3 (total 16), V 6/1/2/1 (total 10), frame 160
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        s_act, s_hs, s_vs, s_ft;
    logic [3:0]  s_r, s_g, s_b;

    // Reduced instance with inverted sync polarities
    logic [10:0] p_x;
    logic [9:0]  p_y;
    logic        p_act, p_hs, p_vs, p_ft;
    logic [3:0]  p_r, p_g, p_b;

    vga_timing dut (
        .clk(clk), .rst_n(rst_n), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .draw_x(d_x), .draw_y(d_y), .active(d_act),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .draw_x(s_x), .draw_y(s_y), .active(s_act),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .draw_x(p_x), .draw_y(p_y), .active(p_act),
        .vga_r(p_r), .vga_g(p_g), .vga_b(p_b),
        .hsync(p_hs), .vsync(p_vs), .frame_tick(p_ft)
    );

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // rising edges since the last reset release
    int first_tick_s = -1;

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_r = 4'hF; pix_g = 4'hF; pix_b = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if ({d_r, d_g, d_b} !== 12'h000) begin
            failures++; $display("FAIL reset_vga got=%h exp=000", {d_r, d_g, d_b});
        end
        checks++;
        if ({d_hs, d_vs, d_ft} !== 3'b100) begin
            failures++; $display("FAIL reset_sync hs/vs/ft got=%b exp=100", {d_hs, d_vs, d_ft});
        end
        checks++;
        if (d_x !== 11'd0 || d_y !== 10'd0 || d_act !== 1'b1) begin
            failures++; $display("FAIL reset_cnt got x=%0d y=%0d act=%b exp 0 0 1", d_x, d_y, d_act);
        end
        checks++;
        if ({p_hs, p_vs} !== 2'b01) begin
            failures++; $display("FAIL reset_pol hs/vs got=%b exp=01", {p_hs, p_vs});
        end
        rst_n = 1'b1;
        k = 0;
        step();
        checks++;
        if ({d_r, d_g, d_b} !== 12'hFFF || d_x !== 11'd1 || d_y !== 10'd0) begin
            failures++;
            $display("FAIL release_first got vga=%h x=%0d y=%0d exp FFF 1 0", {d_r, d_g, d_b}, d_x, d_y);
        end
    endtask

    task automatic test_line();
        int bad_hs = 0, bad_vga = 0, bad_cnt = 0;
        int fall_c = -1, run = 0;
        bit run_done = 0, wrap_seen = 0;
        logic prev_hs = 1'b1;
        logic [10:0] px = '0;
        logic [9:0]  py = '0;
        while (k < 2 * 1904 + 2) begin
            int c, x, y;
            logic exp_hs;
            logic [11:0] exp_v;
            px = d_x; py = d_y;
            step();
            c = k - 1; x = c % 1904; y = c / 1904;
            exp_hs = (x >= 1520 && x < 1672) ? 1'b0 : 1'b1;
            exp_v  = (x < 1440 && y < 900) ? 12'hFFF : 12'h000;
            if (d_hs !== exp_hs) bad_hs++;
            if ({d_r, d_g, d_b} !== exp_v) bad_vga++;
            if (d_x !== 11'(k % 1904) || d_y !== 10'(k / 1904) || d_act !== ((k % 1904) < 1440)) bad_cnt++;
            if (d_hs === 1'b0) begin
                if (prev_hs === 1'b1 && fall_c < 0) fall_c = c;
                if (fall_c >= 0 && !run_done) run++;
            end else if (fall_c >= 0) begin
                run_done = 1;
            end
            prev_hs = d_hs;
            if (s_ft === 1'b1 && first_tick_s < 0) first_tick_s = k;
            if (k == 1904) begin
                wrap_seen = 1;
                checks++;
                if (d_x !== 11'd0 || d_y !== 10'd1 || px !== 11'd1903 || py !== 10'd0) begin
                    failures++;
                    $display("FAIL line_wrap got %0d,%0d -> %0d,%0d exp 1903,0 -> 0,1", px, py, d_x, d_y);
                end
            end
        end
        checks++;
        if (!wrap_seen) begin failures++; $display("FAIL line_wrap_seen got=0 exp=1"); end
        checks++;
        if (bad_hs != 0) begin failures++; $display("FAIL line_hsync bad_cycles=%0d exp=0", bad_hs); end
        checks++;
        if (bad_vga != 0) begin failures++; $display("FAIL line_blank bad_cycles=%0d exp=0", bad_vga); end
        checks++;
        if (bad_cnt != 0) begin failures++; $display("FAIL line_counters bad_cycles=%0d exp=0", bad_cnt); end
        checks++;
        if (fall_c != 1520) begin failures++; $display("FAIL hsync_fall got=%0d exp=1520", fall_c); end
        checks++;
        if (run != 152) begin failures++; $display("FAIL hsync_width got=%0d exp=152", run); end
    endtask

    task automatic test_frame();
        int bad_s = 0, bad_p = 0, vs_total = 0, vs_run = 0, ticks = 0;
        int t1 = -1, t2 = -1, start;
        bit vs_run_done = 0, wraps_ok = 1, double_tick = 0;
        logic prev_ft = 1'b0;
        logic [10:0] px;
        logic [9:0]  py;
        checks++;
        if (first_tick_s != 97) begin failures++; $display("FAIL first_tick got=%0d exp=97", first_tick_s); end
        for (int i = 0; i < 160 && (k % 160) != 0; i++) step();
        start = k;
        while (k < start + 320) begin
            int c, x, y;
            logic in_hs, in_vs;
            logic [11:0] exp_v;
            px = s_x; py = s_y;
            step();
            c = k - 1; x = c % 16; y = (c / 16) % 10;
            in_hs = (x >= 10 && x < 13);
            in_vs = (y >= 7 && y < 9);
            exp_v = (x < 8 && y < 6) ? 12'hFFF : 12'h000;
            if (s_hs !== ~in_hs || s_vs !== in_vs || {s_r, s_g, s_b} !== exp_v
                || s_ft !== (x == 0 && y == 6) || s_x !== 11'(k % 16)
                || s_y !== 10'((k / 16) % 10) || s_act !== ((k % 16) < 8 && ((k / 16) % 10) < 6))
                bad_s++;
            if (p_hs !== in_hs || p_vs !== ~in_vs || {p_r, p_g, p_b} !== exp_v
                || p_ft !== (x == 0 && y == 6) || p_x !== 11'(k % 16)
                || p_y !== 10'((k / 16) % 10) || p_act !== ((k % 16) < 8 && ((k / 16) % 10) < 6))
                bad_p++;
            if (s_vs === 1'b1) begin
                vs_total++;
                if (!vs_run_done) vs_run++;
            end else if (vs_run > 0) begin
                vs_run_done = 1;
            end
            if (s_ft === 1'b1) begin
                ticks++;
                if (prev_ft === 1'b1) double_tick = 1;
                if (t1 < 0) t1 = k; else if (t2 < 0) t2 = k;
            end
            prev_ft = s_ft;
            if ((k % 160) == 0 && (s_x !== 11'd0 || s_y !== 10'd0 || px !== 11'd15 || py !== 10'd9))
                wraps_ok = 0;
        end
        checks++;
        if (bad_s != 0) begin failures++; $display("FAIL frame_small bad_cycles=%0d exp=0", bad_s); end
        checks++;
        if (bad_p != 0) begin failures++; $display("FAIL frame_inv_pol bad_cycles=%0d exp=0", bad_p); end
        checks++;
        if (vs_run != 32 || vs_total != 64) begin
            failures++; $display("FAIL vsync_width got run=%0d total=%0d exp 32 64", vs_run, vs_total);
        end
        checks++;
        if (ticks != 2 || t2 - t1 != 160 || double_tick) begin
            failures++; $display("FAIL frame_tick got count=%0d spacing=%0d double=%0d exp 2 160 0", ticks, t2 - t1, double_tick);
        end
        checks++;
        if (((t1 - 1) % 160) != 96) begin failures++; $display("FAIL tick_pos got=%0d exp=96", (t1 - 1) % 160); end
        checks++;
        if (!wraps_ok) begin failures++; $display("FAIL frame_wrap got=0 exp=1"); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 160 && (k % 160) != 140; i++) step();
        checks++;
        if ({s_hs, s_vs, p_hs, p_vs} !== 4'b0110) begin
            failures++; $display("FAIL pre_reset_sync got=%b exp=0110", {s_hs, s_vs, p_hs, p_vs});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_hs, s_vs, p_hs, p_vs} !== 4'b1001) begin
            failures++; $display("FAIL async_reset_sync got=%b exp=1001", {s_hs, s_vs, p_hs, p_vs});
        end
        checks++;
        if (s_x !== 11'd0 || s_y !== 10'd0 || d_x !== 11'd0 || d_y !== 10'd0 || {d_r, d_g, d_b} !== 12'h000) begin
            failures++;
            $display("FAIL async_reset_cnt got s=%0d,%0d d=%0d,%0d vga=%h exp 0", s_x, s_y, d_x, d_y, {d_r, d_g, d_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        step();
        checks++;
        if (s_x !== 11'd1 || s_y !== 10'd0 || d_x !== 11'd1 || d_y !== 10'd0 || {d_r, d_g, d_b} !== 12'hFFF) begin
            failures++;
            $display("FAIL post_reset got s=%0d,%0d d=%0d,%0d vga=%h exp 1,0 1,0 FFF", s_x, s_y, d_x, d_y, {d_r, d_g, d_b});
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
